cnn_out_dma: RTL

CNN_OUT_DMA -- requirements
Module: cnn_out_dma

---
 rtl/cnn_out_dma_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 56 +++++
 rtl/cnn_out_dma.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cnn_out_dma_pkg.sv
`default_nettype none
// ============================================================================
// cnn_out_dma_pkg : AHB-lite encodings and FSM states for the CNN output DMA
// Revision        : 1.0
// ============================================================================
package cnn_out_dma_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_ERR  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock staging FIFO with occupancy count and flush
// Revision  : 1.0
// ============================================================================
module sync_fifo #(
  parameter int W_DATA     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  logic [W_DATA-1:0]           wr_data,
  input  logic                        pop,
  output logic [W_DATA-1:0]           rd_data,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int W_PTR = $clog2(FIFO_DEPTH);

  logic [W_DATA-1:0] mem [FIFO_DEPTH];
  logic [W_PTR-1:0]  wr_ptr;
  logic [W_PTR-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (count < (W_PTR+1)'(FIFO_DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + W_PTR'(1);
      if (do_pop)  rd_ptr <= rd_ptr + W_PTR'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (W_PTR+1)'(1);
        2'b01:   count <= count - (W_PTR+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cnn_out_dma.sv
`default_nettype none
// ============================================================================
// cnn_out_dma : write-only AHB-lite master draining CNN result words to memory
// Revision    : 1.0
// ============================================================================
module cnn_out_dma
  import cnn_out_dma_pkg::*;
#(
  parameter int W_ADDR     = 32,
  parameter int W_DATA     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int W_CNT      = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              i_start,
  input  logic [W_ADDR-1:0] i_base_addr,
  input  logic [W_CNT-1:0]  i_num_words,
  input  logic              i_valid,
  input  logic [W_DATA-1:0] i_data,
  output logic              o_ready,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  input  logic [W_DATA-1:0] HRDATA,
  output logic [1:0]        out_HTRANS,
  output logic [2:0]        out_HBURST,
  output logic [2:0]        out_HSIZE,
  output logic [W_ADDR-1:0] out_HADDR,
  output logic              out_HWRITE,
  output logic [W_DATA-1:0] out_HWDATA,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int W_FCNT = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  state_t            next_state;
  logic [W_ADDR-1:0] addr;
  logic [W_CNT-1:0]  remaining;
  logic [1:0]        beats;
  logic [2:0]        burst;
  logic              err;
  logic [1:0]        trans;
  logic              arb_go;
  logic              arb_incr4;
  logic              burst_ok;
  logic              push;
  logic              pop;
  logic              flush;
  logic [W_FCNT-1:0] fifo_count;
  logic [W_DATA-1:0] fifo_head;
  logic              unused_ok;

  assign unused_ok = ^HRDATA;

  assign o_busy   = (state != ST_IDLE);
  assign o_ready  = o_busy && (fifo_count < W_FCNT'(FIFO_DEPTH));
  assign push     = i_valid && o_ready;
  assign burst_ok = (addr[3:2] == 2'b00) && (remaining >= W_CNT'(4));

  sync_fifo #(
    .W_DATA     (W_DATA),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (HCLK),
    .rst     (HRESET),
    .flush   (flush),
    .push    (push),
    .wr_data (i_data),
    .pop     (pop),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    trans      = HTRANS_IDLE;
    pop        = 1'b0;
    flush      = 1'b0;
    arb_go     = 1'b0;
    arb_incr4  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) next_state = (i_num_words == '0) ? ST_DONE : ST_ARB;
      end
      ST_ARB: begin
        // An eligible INCR4 waits for all four beats so no BUSY is ever needed.
        if (burst_ok) begin
          if (fifo_count >= W_FCNT'(4)) begin
            arb_go    = 1'b1;
            arb_incr4 = 1'b1;
          end
        end else if (fifo_count != '0) begin
          arb_go = 1'b1;
        end
        if (arb_go) next_state = ST_ADDR;
      end
      ST_ADDR: begin
        trans = HTRANS_NONSEQ;
        if (HREADY) next_state = ST_DATA;
      end
      ST_DATA: begin
        if (beats != 2'd0) trans = HTRANS_SEQ;
        if ((HRESP == HRESP_ERROR) && !HREADY) begin
          trans      = HTRANS_IDLE;
          next_state = ST_ERR;
        end else if (HREADY) begin
          pop = 1'b1;
          if (beats == 2'd0) begin
            next_state = (remaining > W_CNT'(1)) ? ST_ARB : ST_DONE;
          end
        end
      end
      ST_ERR:  next_state = ST_DONE;
      ST_DONE: begin
        flush      = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // beats counts address phases still to be issued after the current one.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr      <= '0;
      remaining <= '0;
      beats     <= 2'd0;
      burst     <= HBURST_SINGLE;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            addr      <= {i_base_addr[W_ADDR-1:2], 2'b00};
            remaining <= i_num_words;
            err       <= 1'b0;
          end
        end
        ST_ARB: begin
          if (arb_go) begin
            burst <= arb_incr4 ? HBURST_INCR4 : HBURST_SINGLE;
            beats <= arb_incr4 ? 2'd3 : 2'd0;
          end
        end
        ST_ADDR: begin
          if (HREADY) addr <= addr + W_ADDR'(4);
        end
        ST_DATA: begin
          if (HREADY && (beats != 2'd0)) begin
            addr  <= addr + W_ADDR'(4);
            beats <= beats - 2'd1;
          end
          if (pop && (remaining != '0)) remaining <= remaining - W_CNT'(1);
        end
        ST_ERR:  err <= 1'b1;
        default: ;
      endcase
    end
  end

  assign out_HTRANS = trans;
  assign out_HBURST = burst;
  assign out_HSIZE  = HSIZE_WORD;
  assign out_HADDR  = addr;
  assign out_HWRITE = 1'b1;
  assign out_HWDATA = (state == ST_DATA) ? fifo_head : '0;
  assign o_done     = (state == ST_DONE);
  assign o_err      = err;

endmodule
`default_nettype wire
